// File: rtl/mult_seq_ctrl.sv
// Sequencer for a shift-and-add sequential multiplier. It owns no operand
// data. It steps the datapath through load, conditional add, shift and
// optional negate, and reports busy/done/result_valid.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mult_lsb,
  input  logic             i_sign_a,
  input  logic             i_sign_b,
  output logic             o_load,
  output logic             o_add_en,
  output logic             o_shift_en,
  output logic             o_neg_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_result_valid,
  output logic [CNT_W-1:0] o_iter
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_FIX   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_iter;
  logic             r_neg;
  logic [CNT_W-1:0] w_iter_inc;
  logic             w_last;

  logic r_load, r_add_en, r_shift_en, r_neg_en, r_busy, r_done, r_result_valid;
  logic w_load, w_add_en, w_shift_en, w_neg_en, w_busy, w_done;

  assign w_iter_inc = r_iter + CNT_W'(1);
  assign w_last     = (w_iter_inc == CNT_W'(WIDTH));

  // Next-state selection plus strobe decode of the upcoming state, so the
  // registered strobes line up exactly with the state they belong to.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_add_en    = 1'b0;
    w_shift_en  = 1'b0;
    w_neg_en    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_TEST;
      S_TEST:  w_state_nxt = i_mult_lsb ? S_ADD : S_SHIFT;
      S_ADD:   w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (!w_last)    w_state_nxt = S_TEST;
        else if (r_neg) w_state_nxt = S_FIX;
        else            w_state_nxt = S_DONE;
      end
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_LOAD:  begin w_load     = 1'b1; w_busy = 1'b1; end
      S_TEST:  w_busy = 1'b1;
      S_ADD:   begin w_add_en   = 1'b1; w_busy = 1'b1; end
      S_SHIFT: begin w_shift_en = 1'b1; w_busy = 1'b1; end
      S_FIX:   begin w_neg_en   = 1'b1; w_busy = 1'b1; end
      S_DONE:  w_done = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // State, iteration count, sign flag and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_iter         <= '0;
      r_neg          <= 1'b0;
      r_load         <= 1'b0;
      r_add_en       <= 1'b0;
      r_shift_en     <= 1'b0;
      r_neg_en       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_load     <= w_load;
      r_add_en   <= w_add_en;
      r_shift_en <= w_shift_en;
      r_neg_en   <= w_neg_en;
      r_busy     <= w_busy;
      r_done     <= w_done;
      if (r_state == S_LOAD) begin
        r_iter <= '0;
        r_neg  <= i_sign_a ^ i_sign_b;
      end else if (r_state == S_SHIFT) begin
        r_iter <= w_iter_inc;
      end
      // result_valid rises together with done and drops when the next load begins
      if (w_state_nxt == S_DONE)      r_result_valid <= 1'b1;
      else if (w_state_nxt == S_LOAD) r_result_valid <= 1'b0;
    end
  end

  assign o_load         = r_load;
  assign o_add_en       = r_add_en;
  assign o_shift_en     = r_shift_en;
  assign o_neg_en       = r_neg_en;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_result_valid = r_result_valid;
  assign o_iter         = r_iter;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl. It models the multiplier shift register so that
// mult_lsb is realistic. It predicts each cycle's strobes from the operand
// bit pattern arithmetically and checks the DUT outputs cycle by cycle.
module tb_mult_seq_ctrl;

  localparam int unsigned W     = 4;
  localparam int unsigned CW    = 3;
  localparam int unsigned MAXC  = 32;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_mult_lsb;
  logic          i_sign_a = 1'b0;
  logic          i_sign_b = 1'b0;
  logic          o_load, o_add_en, o_shift_en, o_neg_en, o_busy, o_done, o_result_valid;
  logic [CW-1:0] o_iter;

  logic [W-1:0]  tb_babs = '0;
  logic [W-1:0]  dp_b = '0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic          rv_state = 1'b0;
  int            prev_iter = 0;

  mult_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mult_lsb(i_mult_lsb),
    .i_sign_a(i_sign_a), .i_sign_b(i_sign_b), .o_load(o_load), .o_add_en(o_add_en),
    .o_shift_en(o_shift_en), .o_neg_en(o_neg_en), .o_busy(o_busy), .o_done(o_done),
    .o_result_valid(o_result_valid), .o_iter(o_iter)
  );

  always #5 i_clk = ~i_clk;

  // Datapath stand-in: multiplier register captures |B| on load, shifts right on shift_en
  always @(posedge i_clk) begin
    if (o_load)          dp_b <= tb_babs;
    else if (o_shift_en) dp_b <= dp_b >> 1;
  end
  assign i_mult_lsb = dp_b[0];

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {o_load, o_add_en, o_shift_en, o_neg_en, o_busy, o_done, o_result_valid};
  endfunction

  // Idle cycles: no strobes, result_valid and iter hold
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      chk("idle_outs", i, 32'(outs()), 32'({6'b0, rv_state}));
      chk("idle_iter", i, 32'(o_iter), 32'(prev_iter));
    end
  endtask

  // One multiply. ign*: cycles in which an extra start pulse is sampled
  // (0 = none). rst_at: cycle in which rst is sampled high (0 = none).
  task automatic run_op(input logic sa, input logic sb, input logic [W-1:0] babs,
                        input int ign1, input int ign2, input int ign3, input int rst_at);
    int shift_at[W];
    int ones, fix, pop, dn, ei;
    logic [6:0] e;
    logic is_shift, is_add;
    ones = 0;
    for (int k = 0; k < W; k++) begin
      ones += int'(babs[k]);
      shift_at[k] = 3 + 2 * k + ones;
    end
    pop = ones;
    fix = int'(sa ^ sb);
    dn  = 2 + 2 * W + pop + fix;

    i_start = 1'b1; i_sign_a = sa; i_sign_b = sb; tb_babs = babs;
    @(posedge i_clk);
    for (int c = 1; c <= dn + 1; c++) begin
      @(negedge i_clk);
      is_shift = 1'b0; is_add = 1'b0; ei = 0;
      for (int k = 0; k < W; k++) begin
        if (c == shift_at[k]) is_shift = 1'b1;
        if (babs[k] && c == shift_at[k] - 1) is_add = 1'b1;
        if (shift_at[k] < c) ei++;
      end
      if (c == 1) ei = prev_iter;
      e = {c == 1, is_add, is_shift, (fix == 1) && (c == dn - 1),
           c < dn, c == dn, c >= dn};
      if (rst_at != 0 && c == rst_at + 1) begin
        chk("rst_outs", c, 32'(outs()), 32'(0));
        chk("rst_iter", c, 32'(o_iter), 32'(0));
        i_rst = 1'b0; i_start = 1'b0;
        rv_state = 1'b0; prev_iter = 0;
        return;
      end
      chk("op_outs", c, 32'(outs()), 32'(e));
      chk("op_iter", c, 32'(o_iter), 32'(ei));
      i_start = (c == ign1 || c == ign2 || c == ign3);
      if (rst_at != 0 && c == rst_at) i_rst = 1'b1;
    end
    i_start = 1'b0;
    rv_state = 1'b1;
    prev_iter = W;
  endtask

  initial begin
    int dn_r, ig1, ig2, rs;
    logic [W-1:0] rb;
    logic rsa, rsb;
    // Reset held two cycles with start asserted; start must not escape reset
    i_rst = 1'b1; i_start = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    chk("reset_outs1", 0, 32'(outs()), 32'(0));
    chk("reset_iter1", 0, 32'(o_iter), 32'(0));
    @(posedge i_clk); @(negedge i_clk);
    chk("reset_outs2", 0, 32'(outs()), 32'(0));
    i_rst = 1'b0; i_start = 1'b0;
    idle_check(2);

    // B=0011 positive: add at 3,6; shifts 4,7,9,11; done at 12
    run_op(1'b0, 1'b0, 4'b0011, 0, 0, 0, 0);
    idle_check(2);
    // B=1111 negative: four adds, negate at 14, done at 15
    run_op(1'b1, 1'b0, 4'b1111, 0, 0, 0, 0);
    idle_check(1);
    // B=0, both negative: no adds, no negate, done at 10; result_valid held
    run_op(1'b1, 1'b1, 4'b0000, 0, 0, 0, 0);
    idle_check(5);
    // Start pulses while busy and in the DONE cycle are ignored
    run_op(1'b0, 1'b0, 4'b0011, 5, 11, 12, 0);
    idle_check(2);
    // Zero product with differing signs still passes through FIX
    run_op(1'b1, 1'b0, 4'b0000, 0, 0, 10, 0);
    idle_check(1);
    // Reset in the middle of a run, with a start on the same edge
    run_op(1'b0, 1'b1, 4'b0101, 6, 0, 0, 6);
    idle_check(2);
    run_op(1'b0, 1'b0, 4'b0011, 0, 0, 0, 0);
    idle_check(1);

    // Randomized operations with stray start pulses and occasional resets
    for (int n = 0; n < 40; n++) begin
      rb  = W'($urandom_range(0, (1 << W) - 1));
      rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      dn_r = 2 + 2 * W + $countones(rb) + int'(rsa ^ rsb);
      ig1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, dn_r)) : 0;
      ig2 = ($urandom_range(0, 3) == 0) ? dn_r : 0;
      rs  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, dn_r - 1)) : 0;
      run_op(rsa, rsb, rb, ig1, ig2, 0, rs);
      idle_check(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
